// File: rtl/imem_stream_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_stream_loader_pkg
// Shared definitions for the instruction-memory stream loader:
//   - loader_state_e : loader FSM states (IDLE, LEN0, LEN1, DATA, FIN)
//   - HDR_BYTES      : bytes in the length header (16-bit word count)
//   - WORD_BYTES     : bytes per instruction word
//   - IDX_WIDTH      : width of the internal word index
//   - depth_words()  : memory depth in words, one bit wider than the index so
//                      that a 2**16-word memory is still representable
// -----------------------------------------------------------------------------
package imem_stream_loader_pkg;

  typedef enum logic [2:0] {
    LS_IDLE = 3'd0,
    LS_LEN0 = 3'd1,
    LS_LEN1 = 3'd2,
    LS_DATA = 3'd3,
    LS_FIN  = 3'd4
  } loader_state_e;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int IDX_WIDTH  = 16;

  function automatic logic [IDX_WIDTH:0] depth_words(input int aw);
    return (IDX_WIDTH + 1)'(1) << aw;
  endfunction

endpackage

// File: rtl/loader_word_pack.sv
// -----------------------------------------------------------------------------
// loader_word_pack
// Packs a byte stream into little-endian words. Byte k of a word lands in
// bits [8k+7:8k]. The final byte of a word is not stored; it is combined
// straight into o_word so the word is available in the same cycle as the
// handshake that completes it.
// Ports:
//   i_clk, i_reset  : clock, asynchronous active-high reset
//   i_clear         : restart packing at byte 0 (new load)
//   i_byte_en       : a data byte is accepted this cycle
//   i_byte          : the accepted byte
//   o_word_valid    : high in the cycle the last byte of a word is accepted
//   o_word          : the assembled word (meaningful when o_word_valid)
// -----------------------------------------------------------------------------
module loader_word_pack
  import imem_stream_loader_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_clear,
  input  logic                      i_byte_en,
  input  logic [7:0]                i_byte,
  output logic                      o_word_valid,
  output logic [8*WORD_BYTES-1:0]   o_word
);

  localparam int CNT_W = $clog2(WORD_BYTES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_BYTES - 1);

  logic [CNT_W-1:0]              r_byte_cnt;
  logic [8*(WORD_BYTES-1)-1:0]   r_lanes;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_byte_cnt <= '0;
    end else if (i_clear) begin
      r_byte_cnt <= '0;
    end else if (i_byte_en) begin
      r_byte_cnt <= (r_byte_cnt == LAST_BYTE) ? '0 : r_byte_cnt + 1'b1;
    end
  end

  // One holding register per lower byte lane; each lane is only written when
  // the byte counter points at it, so stale lanes are always overwritten
  // before the word completes.
  for (genvar gi = 0; gi < WORD_BYTES - 1; gi++) begin : g_lane
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        r_lanes[8*gi +: 8] <= '0;
      end else if (i_byte_en && !i_clear && (r_byte_cnt == CNT_W'(gi))) begin
        r_lanes[8*gi +: 8] <= i_byte;
      end
    end
  end

  assign o_word_valid = i_byte_en && !i_clear && (r_byte_cnt == LAST_BYTE);
  assign o_word       = {i_byte, r_lanes};

endmodule

// File: rtl/imem_stream_loader.sv
// -----------------------------------------------------------------------------
// imem_stream_loader
// Writer side of program memory. After a start pulse it reads a 16-bit word
// count N (low byte first) and then 4*N bytes from a valid/ready byte stream,
// packs them into little-endian words and writes them to instruction memory
// from word address 0 upward. The core is held in reset while loading.
// Parameters:
//   ADDR_WIDTH : word-address width of instruction memory (DEPTH = 2**ADDR_WIDTH)
//   BOOT_WAIT  : 1 = hold core reset after reset until the first load completes
// Ports:
//   i_clk, i_reset  : clock, asynchronous active-high reset
//   i_start         : one-cycle start pulse, ignored while busy
//   i_rx_data/valid : stream byte and its valid; o_rx_ready is the ready
//   o_mem_we/addr/wdata : registered instruction-memory write port
//   o_core_reset    : core reset, high while loading
//   o_busy          : high from accepted start until the end of the done cycle
//   o_done          : one-cycle completion pulse
//   o_err           : sticky overflow flag (image longer than DEPTH words)
// -----------------------------------------------------------------------------
module imem_stream_loader
  import imem_stream_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter bit BOOT_WAIT  = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic                  o_core_reset,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam logic [2:0] S_IDLE = LS_IDLE;
  localparam logic [2:0] S_LEN0 = LS_LEN0;
  localparam logic [2:0] S_LEN1 = LS_LEN1;
  localparam logic [2:0] S_DATA = LS_DATA;
  localparam logic [2:0] S_FIN  = LS_FIN;

  localparam int LEN_BITS = 8 * HDR_BYTES;
  localparam logic [IDX_WIDTH:0] DEPTH = depth_words(ADDR_WIDTH);

  logic [2:0]            r_state;
  logic [LEN_BITS-1:0]   r_len;
  logic [IDX_WIDTH-1:0]  r_index;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic                  r_core_reset;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  r_loaded;

  logic                  w_rx_ready;
  logic                  w_hs;
  logic                  w_byte_en;
  logic                  w_clear;
  logic                  w_word_valid;
  logic [31:0]           w_word;
  logic                  w_in_range;
  logic                  w_last_word;
  logic [LEN_BITS-1:0]   w_len_full;

  assign w_rx_ready  = (r_state == S_LEN0) || (r_state == S_LEN1) || (r_state == S_DATA);
  assign w_hs        = i_rx_valid && w_rx_ready;
  assign w_byte_en   = w_hs && (r_state == S_DATA);
  assign w_clear     = i_start && (r_state == S_IDLE);
  // Index compared one bit wider so a full 2**16-word memory never overflows.
  assign w_in_range  = {1'b0, r_index} < DEPTH;
  // Only evaluated in DATA, where N >= 1, so N-1 never underflows.
  assign w_last_word = (r_index == r_len - 1'b1);
  assign w_len_full  = {i_rx_data, r_len[7:0]};

  loader_word_pack u_word_pack (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (w_clear),
    .i_byte_en    (w_byte_en),
    .i_byte       (i_rx_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_index      <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_reset <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_loaded     <= 1'b0;
    end else begin
      // Write port and done are single-cycle strobes; address and data are
      // only non-zero in the cycle a write is presented.
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_core_reset <= BOOT_WAIT && !r_loaded;
          if (i_start) begin
            r_state      <= S_LEN0;
            r_busy       <= 1'b1;
            r_core_reset <= 1'b1;
            r_err        <= 1'b0;
            r_index      <= '0;
          end
        end
        S_LEN0: begin
          if (w_hs) begin
            r_len[7:0] <= i_rx_data;
            r_state    <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (w_hs) begin
            r_len <= w_len_full;
            if (w_len_full == '0) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_word_valid) begin
            if (w_in_range) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_index[ADDR_WIDTH-1:0];
              r_mem_wdata <= w_word;
            end else begin
              r_err <= 1'b1;
            end
            r_index <= r_index + 1'b1;
            if (w_last_word) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end
          end
        end
        S_FIN: begin
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
          r_core_reset <= 1'b0;
          r_loaded     <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_rx_ready   = w_rx_ready;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_core_reset = r_core_reset;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule
